// File: rtl/sample_delay_line.sv
// Streaming delay line: y[n] = x[n-D], with D programmable at runtime.
// The history lives in a circular-buffer simple dual-port RAM, with valid/ready on both sides.
module sample_delay_line #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] delay,
  input  logic                  delay_load,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] cur_delay
);

  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = ADDR_WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [WIDTH-1:0]      r_rd_data;
  logic [WIDTH-1:0]      r_byp_data;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_fill;
  logic [ADDR_WIDTH-1:0] r_cur_delay;
  logic                  r_out_valid;
  logic                  r_sel_zero;
  logic                  r_sel_byp;

  logic                  w_acc;
  logic [ADDR_WIDTH-1:0] w_eff_delay;
  logic [ADDR_WIDTH-1:0] w_eff_fill;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_fill_nxt;
  logic                  w_zero;
  logic                  w_byp;

  // Single output stage without skid: accept only when the held word leaves.
  assign in_ready = !r_out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;

  // A load on the same cycle as an accept governs that sample.
  assign w_eff_delay = delay_load ? delay : r_cur_delay;
  assign w_eff_fill  = delay_load ? '0 : r_fill;
  assign w_rd_addr   = r_wr_ptr - w_eff_delay;
  assign w_zero      = w_eff_fill < w_eff_delay;
  assign w_byp       = (w_eff_delay == '0);
  assign w_fill_nxt  = (w_eff_fill == FILL_MAX) ? w_eff_fill
                                                : w_eff_fill + ADDR_WIDTH'(1);

  // Storage: synchronous read, no reset; the D=0 collision is covered by the bypass.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mem[r_wr_ptr] <= in_data;
      r_rd_data       <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_cur_delay <= '0;
      r_out_valid <= 1'b0;
      r_sel_zero  <= 1'b1;
      r_sel_byp   <= 1'b0;
      r_byp_data  <= '0;
    end else begin
      if (delay_load) begin
        r_cur_delay <= delay;
        r_fill      <= '0;
      end
      if (w_acc) begin
        r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(1);
        r_fill      <= w_fill_nxt;
        r_sel_zero  <= w_zero;
        r_sel_byp   <= w_byp;
        r_byp_data  <= in_data;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Output word is selected only from flops, so it holds steady through a stall.
  assign out_data  = r_sel_zero ? '0 : (r_sel_byp ? r_byp_data : r_rd_data);
  assign out_valid = r_out_valid;
  assign cur_delay = r_cur_delay;

endmodule

// File: tb/tb_sample_delay_line.sv
// Bench for sample_delay_line: a reference model queues the expected outputs, and a monitor checks each output handshake.
// Directed cases from the plan are followed by a randomized phase with random stalls and reloads.
module tb_sample_delay_line;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    delay;
  logic             delay_load;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    cur_delay;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] obs_q [$];
  logic [WIDTH-1:0] want  [$];
  logic [WIDTH-1:0] hist  [$];
  int unsigned      m_delay = 0;

  sample_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .delay(delay), .delay_load(delay_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cur_delay(cur_delay)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: keep the samples accepted since the last load, and delay by index arithmetic.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hist.delete();
      m_delay = 0;
    end else begin
      if (delay_load) begin
        m_delay = int'(delay);
        hist.delete();
      end
      if (in_valid && in_ready) begin
        hist.push_back(in_data);
        if (hist.size() <= m_delay) exp_q.push_back('0);
        else exp_q.push_back(hist[hist.size() - 1 - m_delay]);
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
    end
  end

  // Monitor: each output handshake retires one expected sample.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      obs_q.push_back(out_data);
      if (exp_q.size() == 0) check("unexpected_output", 32'(out_data), 32'hDEAD);
      else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d);
    delay = AW'(d);
    delay_load = 1'b1;
    cyc();
    delay_load = 1'b0;
    check("cur_delay", 32'(cur_delay), 32'(d));
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input bit do_load = 0, input int ld = 0);
    int  n  = 0;
    bit  ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    if (do_load) begin
      delay      = AW'(ld);
      delay_load = 1'b1;
    end
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      n++;
      cyc();
      delay_load = 1'b0;
    end
    if (!ok) check("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      cyc();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_seq(input string name);
    check({name, "_len"}, 32'(obs_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < obs_q.size(); i++)
      check(name, 32'(obs_q[i]), 32'(want[i]));
    obs_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; delay = '0; delay_load = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) cyc();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data",  32'(out_data),  32'(0));
    check("rst_cur_delay", 32'(cur_delay), 32'(0));
    rst = 1'b0;
    cyc();
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // D=3 zero-fill, then delayed samples.
    load(3);
    for (int i = 1; i <= 6; i++) send(WIDTH'(i));
    drain();
    want = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
    check_seq("d3_seq");

    // D=0 bypass, back to back.
    load(0);
    send(8'hAA);
    send(8'h55);
    drain();
    want = '{8'hAA, 8'h55};
    check_seq("d0_seq");

    // D=DEPTH-1 wraps both pointers.
    load(7);
    for (int i = 1; i <= 20; i++) send(WIDTH'(i));
    drain();
    want.delete();
    for (int i = 0; i < 7; i++) want.push_back('0);
    for (int i = 1; i <= 13; i++) want.push_back(WIDTH'(i));
    check_seq("d7_wrap");

    // Output stall holds data and blocks input.
    load(2);
    send(8'd10);
    send(8'd11);
    send(8'd12);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd13;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'(1));
      check("stall_data",  32'(out_data),  32'(10));
      check("stall_ready", 32'(in_ready),  32'(0));
      cyc();
    end
    out_ready = 1'b1;
    send(8'd13);
    send(8'd14);
    drain();
    want = '{8'd0, 8'd0, 8'd10, 8'd11, 8'd12};
    check_seq("stall_seq");

    // Reload coincident with an accept.
    load(4);
    for (int i = 1; i <= 10; i++) send(WIDTH'(i));
    send(8'd11, 1, 2);
    send(8'd12);
    send(8'd13);
    drain();
    check("reload_cur_delay", 32'(cur_delay), 32'(2));
    want = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd11};
    check_seq("reload_seq");

    // Asynchronous reset while an output is pending.
    load(5);
    send(8'd21);
    check("pre_rst_valid", 32'(out_valid), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'(0));
    check("async_rst_delay", 32'(cur_delay), 32'(0));
    cyc();
    rst = 1'b0;
    obs_q.delete();
    cyc();
    send(8'h31);
    send(8'h32);
    drain();
    want = '{8'h31, 8'h32};
    check_seq("post_rst_seq");

    // Random traffic, stalls, reloads and idle changes on delay.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = WIDTH'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      delay      = AW'($urandom);
      delay_load = ($urandom_range(0, 19) == 0);
      cyc();
    end
    delay_load = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
